// File: rtl/rx_peak_reader_pkg.sv
// Shared definitions for the rx_peak_reader slice.
//
// Holds the peak-report field widths, the packed FIFO entry layout
// {sample, seq, time} and the capture FSM state encoding used by the
// top level. Also provides helpers to pack a report into an entry.
package rx_peak_reader_pkg;

    localparam int SAMPLE_W = 41;
    localparam int SEQ_W    = 4;
    localparam int TIME_W   = 16;
    localparam int ENTRY_W  = SAMPLE_W + SEQ_W + TIME_W;

    // Field order from MSB to LSB: sample, seq, time.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] sample;
        logic [SEQ_W-1:0]           seq;
        logic [TIME_W-1:0]          tstamp;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } cap_state_t;

    function automatic entry_t pack_entry(
        input logic signed [SAMPLE_W-1:0] sample,
        input logic [SEQ_W-1:0]           seq,
        input logic [TIME_W-1:0]          tstamp
    );
        entry_t e;
        e.sample = sample;
        e.seq    = seq;
        e.tstamp = tstamp;
        return e;
    endfunction

endpackage

// File: rtl/rx_peak_fifo.sv
// Synchronous DEPTH-entry FIFO for packed peak reports.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, push_data write request and entry to store
//   push_accepted   high when this cycle's push is taken (combinational)
//   pop             read request; ignored while empty
//   pop_valid       one-cycle pulse after a successful pop
//   pop_data        registered head entry, held until the next pop
//   count           registered occupancy
//   empty, full     registered occupancy flags
module rx_peak_fifo
    import rx_peak_reader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    output logic               push_accepted,
    input  logic               pop,
    output logic               pop_valid,
    output logic [ENTRY_W-1:0] pop_data,
    output logic [PTR_W:0]     count,
    output logic               empty,
    output logic               full
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pop_ok;
    logic [PTR_W:0]     count_next;

    // A pop on a full FIFO frees the slot the push writes into, so a
    // simultaneous push is still accepted. A pop on an empty FIFO is
    // ignored, which means the pushed entry is never bypassed to pop_data.
    assign pop_ok        = pop && !empty;
    assign push_accepted = push && (!full || pop_ok);

    always_comb begin
        count_next = count;
        case ({push_accepted, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage has no reset; only entries between the pointers are valid.
    always_ff @(posedge clk) begin
        if (push_accepted) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The flags
    // are derived from the next occupancy so they stay registered yet
    // always agree with the pointers after each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= pop_ok;
            if (push_accepted) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (PTR_W+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/rx_peak_reader.sv
// Consumer end of the rx_top_level peak-report handshake.
//
// Captures each report presented on i_trigger_arm, answers it with a
// one-cycle o_result_acquired_arm pulse and buffers it in a FIFO that the
// ARM side drains through i_rd_req. Reports arriving while the FIFO is
// full are dropped and flagged through o_overflow / o_drop_cnt.
//
// Ports:
//   crx_clk, rrx_rst          clock, asynchronous active-high reset
//   erx_en                    capture enable
//   i_sample_arm/seq/time     peak report fields, valid with i_trigger_arm
//   o_result_acquired_arm     acknowledge pulse back to rx_top_level
//   i_rd_req                  pop request
//   o_rd_valid, o_rd_*        popped entry, pulse plus held data
//   o_count, o_empty, o_full  FIFO occupancy status
//   o_overflow, o_drop_cnt    sticky drop flag and saturating drop count
//   i_clr_overflow            clears the drop flag and count
module rx_peak_reader
    import rx_peak_reader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       erx_en,
    input  logic signed [SAMPLE_W-1:0] i_sample_arm,
    input  logic [SEQ_W-1:0]           i_received_seq,
    input  logic [TIME_W-1:0]          i_time_arm,
    input  logic                       i_trigger_arm,
    output logic                       o_result_acquired_arm,
    input  logic                       i_rd_req,
    output logic                       o_rd_valid,
    output logic signed [SAMPLE_W-1:0] o_rd_sample,
    output logic [SEQ_W-1:0]           o_rd_seq,
    output logic [TIME_W-1:0]          o_rd_time,
    output logic [PTR_W:0]             o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic [CNT_W-1:0]           o_drop_cnt,
    input  logic                       i_clr_overflow
);

    cap_state_t         state;
    cap_state_t         next_state;
    entry_t             latched;
    entry_t             popped;
    logic               capture;
    logic               push;
    logic               push_accepted;
    logic               drop;
    logic [ENTRY_W-1:0] pop_data;

    assign capture = (state == IDLE) && erx_en && i_trigger_arm;
    assign push    = (state == ACK);
    assign drop    = push && !push_accepted;

    // The ack is decoded straight from the state register, so it is
    // glitch-free and falls immediately when reset is asserted.
    assign o_result_acquired_arm = (state == ACK);

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ACK always lasts exactly one cycle. WAIT_LOW holds off until the
    // producer releases the trigger so a held trigger is one report only.
    // Dropping the enable returns to IDLE, but an ACK already under way
    // still completes its push.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (erx_en && i_trigger_arm) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = erx_en ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                if (!erx_en || !i_trigger_arm) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            latched <= '0;
        end else if (capture) begin
            latched <= pack_entry(i_sample_arm, i_received_seq, i_time_arm);
        end
    end

    // A drop wins over a clear in the same cycle, restarting the count at 1.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (i_clr_overflow) begin
                o_drop_cnt <= CNT_W'(1);
            end else if (o_drop_cnt != '1) begin
                o_drop_cnt <= o_drop_cnt + 1'b1;
            end
        end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end
    end

    rx_peak_fifo #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_fifo (
        .clk          (crx_clk),
        .rst          (rrx_rst),
        .push         (push),
        .push_data    (latched),
        .push_accepted(push_accepted),
        .pop          (i_rd_req),
        .pop_valid    (o_rd_valid),
        .pop_data     (pop_data),
        .count        (o_count),
        .empty        (o_empty),
        .full         (o_full)
    );

    assign popped      = entry_t'(pop_data);
    assign o_rd_sample = popped.sample;
    assign o_rd_seq    = popped.seq;
    assign o_rd_time   = popped.tstamp;

endmodule

// File: tb/tb_rx_peak_reader.sv
// Directed self-checking bench for rx_peak_reader.
//
// Acts as the rx_top_level report producer and the ARM-side reader,
// driving a linear sequence of hand-computed scenarios and comparing
// every observed output against constants held in the bench.
module tb_rx_peak_reader;

    logic               crx_clk = 1'b0;
    logic               rrx_rst;
    logic               erx_en;
    logic signed [40:0] i_sample_arm;
    logic [3:0]         i_received_seq;
    logic [15:0]        i_time_arm;
    logic               i_trigger_arm;
    logic               o_result_acquired_arm;
    logic               i_rd_req;
    logic               o_rd_valid;
    logic signed [40:0] o_rd_sample;
    logic [3:0]         o_rd_seq;
    logic [15:0]        o_rd_time;
    logic [3:0]         o_count;
    logic               o_empty;
    logic               o_full;
    logic               o_overflow;
    logic [7:0]         o_drop_cnt;
    logic               i_clr_overflow;

    int errors = 0;
    int checks = 0;

    rx_peak_reader #(
        .DEPTH(8),
        .PTR_W(3),
        .CNT_W(8)
    ) dut (
        .crx_clk              (crx_clk),
        .rrx_rst              (rrx_rst),
        .erx_en               (erx_en),
        .i_sample_arm         (i_sample_arm),
        .i_received_seq       (i_received_seq),
        .i_time_arm           (i_time_arm),
        .i_trigger_arm        (i_trigger_arm),
        .o_result_acquired_arm(o_result_acquired_arm),
        .i_rd_req             (i_rd_req),
        .o_rd_valid           (o_rd_valid),
        .o_rd_sample          (o_rd_sample),
        .o_rd_seq             (o_rd_seq),
        .o_rd_time            (o_rd_time),
        .o_count              (o_count),
        .o_empty              (o_empty),
        .o_full               (o_full),
        .o_overflow           (o_overflow),
        .o_drop_cnt           (o_drop_cnt),
        .i_clr_overflow       (i_clr_overflow)
    );

    always #5 crx_clk = ~crx_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge crx_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one report, keep the trigger high for 'hold' extra cycles
    // after the ack, then release it and let the FSM return to IDLE.
    // Every ack pulse seen on the way is counted.
    task automatic applyStimulus(input logic signed [40:0] s, input logic [3:0] q,
                                 input logic [15:0] t, input int hold, output int acks);
        int  waited;
        bit  seen;
        acks           = 0;
        waited         = 0;
        seen           = 1'b0;
        i_sample_arm   = s;
        i_received_seq = q;
        i_time_arm     = t;
        i_trigger_arm  = 1'b1;
        while (!seen && waited < 8) begin
            tick();
            waited++;
            if (o_result_acquired_arm) begin
                acks++;
                seen = 1'b1;
            end
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            if (o_result_acquired_arm) acks++;
        end
        i_trigger_arm = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (o_result_acquired_arm) acks++;
        end
    endtask

    task automatic popEntry(input string tag, input logic signed [40:0] s,
                            input logic [3:0] q, input logic [15:0] t);
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        checkOutput({tag, "_valid"}, 64'(o_rd_valid), 64'(1'b1));
        checkOutput({tag, "_sample"}, 64'(o_rd_sample), 64'(s));
        checkOutput({tag, "_seq"}, 64'(o_rd_seq), 64'(q));
        checkOutput({tag, "_time"}, 64'(o_rd_time), 64'(t));
        tick();
        checkOutput({tag, "_valid_drop"}, 64'(o_rd_valid), 64'(1'b0));
    endtask

    localparam logic signed [40:0] S1   = -41'sd12345;
    localparam logic signed [40:0] SH   = 41'sd77;
    localparam logic signed [40:0] SX   = -41'sd999999;
    localparam logic signed [40:0] SY   = 41'sd4242;
    localparam logic signed [40:0] SZ   = -41'sd31;
    localparam logic signed [40:0] SW   = -41'sd1;

    logic signed [40:0] rs [10];
    logic [3:0]         rq [10];
    logic [15:0]        rt [10];

    initial begin
        int acks;
        int total_acks;

        rrx_rst        = 1'b1;
        erx_en         = 1'b0;
        i_sample_arm   = '0;
        i_received_seq = '0;
        i_time_arm     = '0;
        i_trigger_arm  = 1'b0;
        i_rd_req       = 1'b0;
        i_clr_overflow = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rs[i] = 41'(1000 * i - 4500);
            rq[i] = 4'(i + 1);
            rt[i] = 16'(16'h0100 + i);
        end

        // Reset state
        tick();
        tick();
        checkOutput("rst_count", 64'(o_count), 64'(0));
        checkOutput("rst_empty", 64'(o_empty), 64'(1));
        checkOutput("rst_full", 64'(o_full), 64'(0));
        checkOutput("rst_ack", 64'(o_result_acquired_arm), 64'(0));
        checkOutput("rst_overflow", 64'(o_overflow), 64'(0));
        checkOutput("rst_drop_cnt", 64'(o_drop_cnt), 64'(0));
        checkOutput("rst_rd_valid", 64'(o_rd_valid), 64'(0));
        checkOutput("rst_rd_sample", 64'(o_rd_sample), 64'(0));
        rrx_rst = 1'b0;
        erx_en  = 1'b1;
        tick();

        // Single report, then pop it back
        applyStimulus(S1, 4'd12, 16'h1A2B, 0, acks);
        checkOutput("single_acks", 64'(acks), 64'(1));
        checkOutput("single_count", 64'(o_count), 64'(1));
        checkOutput("single_empty", 64'(o_empty), 64'(0));
        popEntry("single_pop", S1, 4'd12, 16'h1A2B);
        checkOutput("single_empty_after", 64'(o_empty), 64'(1));

        // Trigger held for 20 cycles after the ack is one capture only
        applyStimulus(SH, 4'd3, 16'h0033, 20, acks);
        checkOutput("held_acks", 64'(acks), 64'(1));
        checkOutput("held_count", 64'(o_count), 64'(1));
        popEntry("held_pop", SH, 4'd3, 16'h0033);

        // Ten reports with no reads: eight stored, two dropped
        total_acks = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(rs[i], rq[i], rt[i], 0, acks);
            total_acks += acks;
        end
        checkOutput("fill_acks", 64'(total_acks), 64'(10));
        checkOutput("fill_count", 64'(o_count), 64'(8));
        checkOutput("fill_full", 64'(o_full), 64'(1));
        checkOutput("fill_overflow", 64'(o_overflow), 64'(1));
        checkOutput("fill_drop_cnt", 64'(o_drop_cnt), 64'(2));

        // Full FIFO: push and pop in the same cycle, no drop
        i_sample_arm   = SX;
        i_received_seq = 4'd9;
        i_time_arm     = 16'hBEEF;
        i_trigger_arm  = 1'b1;
        tick();
        checkOutput("simul_ack", 64'(o_result_acquired_arm), 64'(1));
        i_rd_req      = 1'b1;
        i_trigger_arm = 1'b0;
        tick();
        i_rd_req = 1'b0;
        checkOutput("simul_valid", 64'(o_rd_valid), 64'(1));
        checkOutput("simul_sample", 64'(o_rd_sample), 64'(rs[0]));
        checkOutput("simul_seq", 64'(o_rd_seq), 64'(rq[0]));
        checkOutput("simul_count", 64'(o_count), 64'(8));
        checkOutput("simul_full", 64'(o_full), 64'(1));
        checkOutput("simul_drop_cnt", 64'(o_drop_cnt), 64'(2));
        tick();

        // Drain in order: reports 2..8 then the simultaneously pushed one
        for (int i = 1; i < 8; i++) begin
            popEntry($sformatf("drain%0d", i), rs[i], rq[i], rt[i]);
        end
        popEntry("drain_tail", SX, 4'd9, 16'hBEEF);
        checkOutput("drain_empty", 64'(o_empty), 64'(1));
        checkOutput("drain_count", 64'(o_count), 64'(0));

        // Pop while empty is ignored and keeps the last popped data
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        checkOutput("empty_pop_valid", 64'(o_rd_valid), 64'(0));
        checkOutput("empty_pop_sample", 64'(o_rd_sample), 64'(SX));
        checkOutput("empty_pop_time", 64'(o_rd_time), 64'(16'hBEEF));
        checkOutput("empty_pop_count", 64'(o_count), 64'(0));

        // Clear the overflow flag and drop counter
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        checkOutput("clr_overflow", 64'(o_overflow), 64'(0));
        checkOutput("clr_drop_cnt", 64'(o_drop_cnt), 64'(0));

        // Capture disabled: no ack, nothing stored
        erx_en        = 1'b0;
        i_trigger_arm = 1'b1;
        acks          = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (o_result_acquired_arm) acks++;
        end
        checkOutput("disabled_acks", 64'(acks), 64'(0));
        checkOutput("disabled_count", 64'(o_count), 64'(0));
        i_trigger_arm = 1'b0;
        erx_en        = 1'b1;
        tick();

        // Reset asserted during ACK
        applyStimulus(SY, 4'd5, 16'h5555, 0, acks);
        checkOutput("pre_rst_count", 64'(o_count), 64'(1));
        i_sample_arm   = SZ;
        i_received_seq = 4'd6;
        i_time_arm     = 16'h6666;
        i_trigger_arm  = 1'b1;
        tick();
        checkOutput("ack_before_rst", 64'(o_result_acquired_arm), 64'(1));
        #2;
        rrx_rst = 1'b1;
        #1;
        checkOutput("ack_in_rst", 64'(o_result_acquired_arm), 64'(0));
        checkOutput("count_in_rst", 64'(o_count), 64'(0));
        checkOutput("empty_in_rst", 64'(o_empty), 64'(1));
        i_trigger_arm = 1'b0;
        tick();
        rrx_rst = 1'b0;
        tick();

        // Next report after reset is captured normally
        applyStimulus(SW, 4'd15, 16'hFFFF, 0, acks);
        checkOutput("post_rst_acks", 64'(acks), 64'(1));
        checkOutput("post_rst_count", 64'(o_count), 64'(1));
        popEntry("post_rst_pop", SW, 4'd15, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
